// File: rtl/alu_unit.sv
// Registered WIDTH-bit ALU execution stage with one cycle of latency.
// The result is WIDTH+1 bits wide: the MSB carries the add carry-out or the subtract borrow.
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP_SEL,
  output logic [WIDTH:0]   Out_with_carry,
  output logic             out_valid,
  output logic             zero,
  output logic             carry
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_NOT = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_RSV = 3'b111
  } aluOpE;

  aluOpE            opSel;
  logic [WIDTH:0]   opA;
  logic [WIDTH:0]   opB;
  logic [WIDTH:0]   result_d;
  logic             zero_d;
  logic [WIDTH:0]   result_q;
  logic             zero_q;
  logic             carry_q;
  logic             valid_q;

  assign opSel = aluOpE'(OP_SEL);
  assign opA   = {1'b0, A};
  assign opB   = {1'b0, B};

  // Every operation is evaluated at WIDTH+1 bits; logic ops leave the MSB clear.
  // Unlisted or unknown selects fall to the default and produce zero.
  always_comb begin
    result_d = '0;
    case (opSel)
      OP_ADD:  result_d = opA + opB;
      OP_SUB:  result_d = opA - opB;
      OP_NOT:  result_d = {1'b0, ~A};
      OP_AND:  result_d = {1'b0, A & B};
      OP_OR:   result_d = {1'b0, A | B};
      OP_XOR:  result_d = {1'b0, A ^ B};
      default: result_d = '0;
    endcase
    zero_d = (result_d[WIDTH-1:0] == '0);
  end

  // The result and flags update only on accepted inputs; the valid flag follows in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= zero_d;
        carry_q  <= result_d[WIDTH];
      end
    end
  end

  assign Out_with_carry = result_q;
  assign out_valid      = valid_q;
  assign zero           = zero_q;
  assign carry          = carry_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed literal cases plus randomized traffic checked
// every cycle against an integer-arithmetic model of the ALU stage.
module tb_alu_unit;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic             inValid;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       opSel;
  logic [WIDTH:0]   outWithCarry;
  logic             outValid;
  logic             zeroFlag;
  logic             carryFlag;

  int checks = 0;
  int errors = 0;

  int modelRes   = 0;
  bit modelValid = 0;
  bit modelZero  = 0;
  bit modelCarry = 0;
  bit modelArmed = 0;

  alu_unit #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (inValid),
    .A              (opA),
    .B              (opB),
    .OP_SEL         (opSel),
    .Out_with_carry (outWithCarry),
    .out_valid      (outValid),
    .zero           (zeroFlag),
    .carry          (carryFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic on plain integers; the subtract wraps modulo 2^(WIDTH+1).
  function automatic int modelResult(int a, int b, int op);
    case (op)
      1:       return a + b;
      2:       return (a - b + 2 * MOD) % (2 * MOD);
      3:       return (MOD - 1) - a;
      4:       return a & b;
      5:       return a | b;
      6:       return a ^ b;
      default: return 0;
    endcase
  endfunction

  function automatic void checkEq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // The model tracks what the stage must be holding after each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      modelRes   = 0;
      modelValid = 0;
      modelZero  = 0;
      modelCarry = 0;
    end else begin
      modelValid = inValid;
      if (inValid) begin
        modelRes   = modelResult(int'(opA), int'(opB), int'(opSel));
        modelZero  = ((modelRes % MOD) == 0);
        modelCarry = (modelRes >= MOD);
      end
    end
    modelArmed = 1;
  end

  // Outputs are compared with the model on every falling edge once the model has seen an edge.
  always @(negedge clk) begin
    if (modelArmed) begin
      checkEq("model.result", 32'(outWithCarry), 32'(modelRes));
      checkEq("model.valid",  32'(outValid),     32'(modelValid));
      checkEq("model.zero",   32'(zeroFlag),     32'(modelZero));
      checkEq("model.carry",  32'(carryFlag),    32'(modelCarry));
    end
  end

  // Called on a falling edge: drives one input set and returns on the next falling edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [2:0] op, input logic v);
    opA     = a;
    opB     = b;
    opSel   = op;
    inValid = v;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH:0] expRes,
                             input logic expValid, input logic expZero, input logic expCarry);
    checkEq({name, ".result"}, 32'(outWithCarry), 32'(expRes));
    checkEq({name, ".valid"},  32'(outValid),     32'(expValid));
    checkEq({name, ".zero"},   32'(zeroFlag),     32'(expZero));
    checkEq({name, ".carry"},  32'(carryFlag),    32'(expCarry));
  endtask

  initial begin
    rst     = 1'b1;
    inValid = 1'b0;
    opA     = '0;
    opB     = '0;
    opSel   = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 9'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    applyStimulus(8'd10,  8'd20,  3'b001, 1'b1); checkOutput("add10_20",  9'd30,          1, 0, 0);
    applyStimulus(8'd30,  8'd15,  3'b010, 1'b1); checkOutput("sub30_15",  9'd15,          1, 0, 0);
    applyStimulus(8'd15,  8'd30,  3'b010, 1'b1); checkOutput("sub15_30",  9'b1_1111_0001, 1, 0, 1);
    applyStimulus(8'd200, 8'd100, 3'b001, 1'b1); checkOutput("add200_100", 9'h12C,        1, 0, 1);
    applyStimulus(8'd255, 8'd1,   3'b001, 1'b1); checkOutput("add255_1",  9'h100,         1, 1, 1);
    applyStimulus(8'd5,   8'd77,  3'b011, 1'b1); checkOutput("not5",      9'b0_1111_1010, 1, 0, 0);
    applyStimulus(8'hCC,  8'hAA,  3'b100, 1'b1); checkOutput("and",       9'b0_1000_1000, 1, 0, 0);
    applyStimulus(8'hCC,  8'hAA,  3'b101, 1'b1); checkOutput("or",        9'b0_1110_1110, 1, 0, 0);
    applyStimulus(8'hCC,  8'hAA,  3'b110, 1'b1); checkOutput("xor",       9'b0_0110_0110, 1, 0, 0);
    applyStimulus(8'h5A,  8'h33,  3'b000, 1'b1); checkOutput("nop",       9'd0,           1, 1, 0);
    applyStimulus(8'hFF,  8'hFF,  3'b111, 1'b1); checkOutput("reserved",  9'd0,           1, 1, 0);
    applyStimulus(8'hFF,  8'hFF,  3'b110, 1'b1); checkOutput("xor_self",  9'd0,           1, 1, 0);

    // Streaming burst on consecutive cycles ending in a hold.
    applyStimulus(8'd1,   8'd2,   3'b001, 1'b1); checkOutput("stream0", 9'd3,   1, 0, 0);
    applyStimulus(8'd9,   8'd4,   3'b010, 1'b1); checkOutput("stream1", 9'd5,   1, 0, 0);
    applyStimulus(8'hF0,  8'h0F,  3'b101, 1'b1); checkOutput("stream2", 9'hFF,  1, 0, 0);
    applyStimulus(8'h00,  8'h01,  3'b010, 1'b1); checkOutput("stream3", 9'h1FF, 1, 0, 1);
    applyStimulus(8'hFF,  8'h00,  3'b011, 1'b1); checkOutput("stream4", 9'd0,   1, 1, 0);
    applyStimulus(8'd128, 8'd128, 3'b001, 1'b1); checkOutput("stream5", 9'h100, 1, 1, 1);
    applyStimulus(8'd7,   8'd7,   3'b001, 1'b0); checkOutput("hold0",   9'h100, 0, 1, 1);
    applyStimulus(8'd3,   8'd1,   3'b010, 1'b0); checkOutput("hold1",   9'h100, 0, 1, 1);

    // A reset on the same edge as a valid input discards that input.
    applyStimulus(8'd10,  8'd20,  3'b001, 1'b1); checkOutput("preRst",  9'd30,  1, 0, 0);
    rst = 1'b1;
    applyStimulus(8'd40,  8'd2,   3'b001, 1'b1); checkOutput("rstValid", 9'd0,  0, 0, 0);
    rst = 1'b0;
    applyStimulus(8'd40,  8'd2,   3'b001, 1'b0); checkOutput("postRst",  9'd0,  0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom),
                    ($urandom_range(0, 3) != 0));
    end
    rst     = 1'b0;
    inValid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
